// File: rtl/lupdate.sv
// lupdate: beacon-update receiver; consumes local update messages and forwards all other packets with a 3-cycle delay
module lupdate #(
    parameter logic [7:0]  LMID      = 8'd12,
    parameter logic [15:0] ETHERTYPE = 16'h88f7,
    parameter logic [3:0]  UPD_TYPE  = 4'hd
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_lu_data_wr,
    input  logic [133:0] in_lu_data,
    input  logic         in_lu_data_valid,
    input  logic         in_lu_data_valid_wr,
    input  logic [47:0]  in_local_mac_id,
    output logic         out_lu_data_wr,
    output logic [133:0] out_lu_data,
    output logic         out_lu_data_valid,
    output logic         out_lu_data_valid_wr,
    output logic [47:0]  direct_mac_addr,
    output logic         direction,
    output logic [31:0]  token_bucket_para,
    output logic [31:0]  time_slot_period,
    output logic         beacon_update_master,
    output logic [15:0]  update_cnt,
    output logic [15:0]  err_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_CONS} state_t;

    state_t        r_state, w_nstate;
    logic [2:0]    r_k, w_nk;
    logic          r_orphan, w_norphan;
    logic          w_head, w_tail, w_upd;
    logic          w_pend, w_drop, w_resolve, w_res_drop;
    logic          w_err, w_apply, w_cap;
    logic [133:0]  w_din;

    logic [2:0]    r_wr, r_vld, r_vwr, r_drop;
    logic [1:0]    r_pend;
    logic [133:0]  r_dat [3];

    logic [47:0]   r_dmac, r_sdmac, w_fdmac;
    logic          r_dir, r_sdir, w_fdir;
    logic [31:0]   r_tb, r_stb, w_ftb;
    logic [31:0]   r_ts, r_sts, w_fts;
    logic          r_bm;
    logic [15:0]   r_ucnt, r_ecnt;

    assign w_head = in_lu_data[133:132] == 2'b01;
    assign w_tail = in_lu_data[133:132] == 2'b10;
    assign w_upd  = (in_lu_data[127:80] == in_local_mac_id) &&
                    (in_lu_data[31:16] == ETHERTYPE) &&
                    (in_lu_data[11:8] == UPD_TYPE);

    // word 6 fields, bypassed when word 6 is the tail being applied this cycle
    assign w_fdmac = w_cap ? in_lu_data[127:80] : r_sdmac;
    assign w_fdir  = w_cap ? in_lu_data[79]     : r_sdir;
    assign w_ftb   = w_cap ? in_lu_data[63:32]  : r_stb;
    assign w_fts   = w_cap ? in_lu_data[31:0]   : r_sts;

    // head words get the LMID stamp on entry to the delay line
    always_comb begin
        w_din = in_lu_data;
        if (in_lu_data_wr && w_head) w_din[87:80] = LMID;
    end

    // parser state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= 3'd0;
            r_orphan <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_k      <= w_nk;
            r_orphan <= w_norphan;
        end
    end

    // next state, per-word drop/pending tags, counter events
    always_comb begin
        w_nstate   = r_state;
        w_nk       = r_k;
        w_norphan  = r_orphan;
        w_pend     = 1'b0;
        w_drop     = 1'b0;
        w_resolve  = 1'b0;
        w_res_drop = 1'b0;
        w_err      = 1'b0;
        w_apply    = 1'b0;
        w_cap      = 1'b0;
        if (in_lu_data_wr && w_head) begin
            w_nstate  = S_HDR;
            w_nk      = 3'd1;
            w_pend    = 1'b1;
            w_norphan = 1'b0;
            w_err     = r_state != S_IDLE;
            w_resolve = r_state == S_HDR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_norphan = in_lu_data_wr;
                    w_drop    = in_lu_data_wr;
                    w_err     = in_lu_data_wr && !r_orphan;
                end
                S_HDR: begin
                    w_resolve  = !(in_lu_data_wr && !w_tail && r_k == 3'd1);
                    w_res_drop = in_lu_data_wr && r_k == 3'd2 && w_upd;
                    if (!in_lu_data_wr) begin
                        w_err    = 1'b1;
                        w_nstate = S_IDLE;
                    end else if (r_k == 3'd1) begin
                        w_nstate = w_tail ? S_IDLE : S_HDR;
                        w_pend   = !w_tail;
                        w_nk     = 3'd2;
                    end else begin
                        w_drop   = w_upd;
                        w_nk     = 3'd3;
                        w_err    = w_tail && w_upd;
                        w_nstate = w_tail ? S_IDLE : (w_upd ? S_CONS : S_FWD);
                    end
                end
                S_FWD: begin
                    w_err    = !in_lu_data_wr;
                    w_nstate = (!in_lu_data_wr || w_tail) ? S_IDLE : S_FWD;
                end
                default: begin
                    w_drop = 1'b1;
                    if (!in_lu_data_wr) begin
                        w_err    = 1'b1;
                        w_nstate = S_IDLE;
                    end else begin
                        w_cap = r_k == 3'd6;
                        w_nk  = (r_k == 3'd7) ? 3'd7 : r_k + 3'd1;
                        if (w_tail) begin
                            w_nstate = S_IDLE;
                            w_apply  = r_k >= 3'd6 && in_lu_data_valid && in_lu_data_valid_wr;
                            w_err    = !w_apply;
                        end
                    end
                end
            endcase
        end
    end

    // 3-stage delay line; pending words take the packet decision when it is made
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr     <= 3'd0;
            r_vld    <= 3'd0;
            r_vwr    <= 3'd0;
            r_drop   <= 3'd0;
            r_pend   <= 2'd0;
            r_dat[0] <= '0;
            r_dat[1] <= '0;
            r_dat[2] <= '0;
        end else begin
            r_wr     <= {r_wr[1:0], in_lu_data_wr};
            r_vld    <= {r_vld[1:0], in_lu_data_valid};
            r_vwr    <= {r_vwr[1:0], in_lu_data_valid_wr};
            r_pend   <= {r_pend[0] & ~w_resolve, w_pend};
            r_drop   <= {(r_pend[1] & w_resolve) ? w_res_drop : r_drop[1],
                         (r_pend[0] & w_resolve) ? w_res_drop : r_drop[0],
                         w_drop};
            r_dat[0] <= w_din;
            r_dat[1] <= r_dat[0];
            r_dat[2] <= r_dat[1];
        end
    end

    // shadow capture, config apply and event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdmac <= 48'd0;
            r_sdir  <= 1'b0;
            r_stb   <= 32'd0;
            r_sts   <= 32'd0;
            r_dmac  <= 48'd0;
            r_dir   <= 1'b0;
            r_tb    <= 32'd0;
            r_ts    <= 32'd0;
            r_bm    <= 1'b0;
            r_ucnt  <= 16'd0;
            r_ecnt  <= 16'd0;
        end else begin
            if (w_cap) begin
                r_sdmac <= w_fdmac;
                r_sdir  <= w_fdir;
                r_stb   <= w_ftb;
                r_sts   <= w_fts;
            end
            if (w_apply) begin
                r_dmac <= w_fdmac;
                r_dir  <= w_fdir;
                r_tb   <= w_ftb;
                r_ts   <= w_fts;
                r_bm   <= ~r_bm;
                r_ucnt <= r_ucnt + 16'd1;
            end
            if (w_err) r_ecnt <= r_ecnt + 16'd1;
        end
    end

    assign out_lu_data_wr       = r_wr[2] & ~r_drop[2];
    assign out_lu_data          = r_dat[2];
    assign out_lu_data_valid    = r_vld[2];
    assign out_lu_data_valid_wr = r_vwr[2] & ~r_drop[2];
    assign direct_mac_addr      = r_dmac;
    assign direction            = r_dir;
    assign token_bucket_para    = r_tb;
    assign time_slot_period     = r_ts;
    assign beacon_update_master = r_bm;
    assign update_cnt           = r_ucnt;
    assign err_cnt              = r_ecnt;
endmodule

// File: doc/lupdate.md
# lupdate

Beacon-update receiver on the 134-bit UM packet bus, placed upstream of the beacon report generator. It classifies each packet by its Ethernet header word. Beacon update messages addressed to this node are consumed: their config fields are latched and a toggle handshake is raised toward the report generator. All other packets pass through after a fixed 3-cycle delay, with the LMID stamped into the head word.

## Interface
- LMID, 8'd12, module ID written to head-word bits [87:80] of forwarded packets
- ETHERTYPE, 16'h88f7, required ethertype of an update message
- UPD_TYPE, 4'hd, required message type of an update message

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_lu_data_wr  in  1  word strobe
- in_lu_data  in  134  [133:132] 01 head / 11 middle / 10 tail, [127:0] payload
- in_lu_data_valid  in  1  packet-valid flag, meaningful on tail
- in_lu_data_valid_wr  in  1  strobe for in_lu_data_valid
- in_local_mac_id  in  48  this node's MAC
- out_lu_data_wr / out_lu_data / out_lu_data_valid / out_lu_data_valid_wr  out  1/134/1/1  forwarded stream
- direct_mac_addr  out  48  latched config
- direction  out  1  latched config
- token_bucket_para  out  32  latched config
- time_slot_period  out  32  latched config
- beacon_update_master  out  1  toggles once per applied update
- update_cnt  out  16  applied updates, wraps
- err_cnt  out  16  malformed packets, wraps

## Operation
- Word index k counts wr cycles from head (head = 0). Words 0-1 are metadata.
- Word 2 layout: [127:80] dmac, [79:32] smac, [31:16] ethertype, [11:8] msg type.
- Word 6 layout: [127:80] direct_mac_addr, [79] direction, [63:32] token_bucket_para, [31:0] time_slot_period.
- Packet is an update iff, at word 2: dmac == in_local_mac_id, ethertype == ETHERTYPE, msg type == UPD_TYPE.
- Parser FSM states:
  - IDLE: head with wr -> HDR.
  - HDR: waits for word 2; decides update -> CONSUME, else FWD. A tail at k<2 forwards the packet and returns to IDLE.
  - FWD: forwards until tail -> IDLE.
  - CONSUME: word 6 captured into shadow registers; tail -> IDLE.
- Update apply, at the tail of a CONSUME packet:
  - Requires k ≥ 6, in_lu_data_valid=1 and in_lu_data_valid_wr=1.
  - Shadow registers copy to the config outputs.
  - beacon_update_master inverts; update_cnt +1.
  - Otherwise (short packet or valid=0): no config change, err_cnt +1.
- A consumed packet produces no out_lu_data_wr on any of its words.
- Forwarded packet: words unchanged except head bits [87:80] = LMID; valid/valid_wr pass through with the tail word.
- Error, wr=0 between head and tail: err_cnt +1, FSM -> IDLE.
  - Words already classified keep their decision.
  - Words of the interrupted packet still in the delay line are handled per their decision (an unclassified packet is forwarded).
- Error, non-head word with wr=1 in IDLE (orphan): dropped, err_cnt +1 once per orphan run.
- Head arriving in a non-IDLE state: the current packet is treated as aborted (err_cnt +1), and the new head starts HDR.
- Counters wrap 16'hffff -> 0.

## Timing
- Input words enter a 3-stage delay line every cycle, bubbles included. out_* equals in_* delayed exactly 3 clk cycles, with wr masked for dropped words.
- Drop/forward decision for word 0 is taken on the cycle word 2 is sampled, which is the same cycle word 0 leaves stage 2. Word 2 is therefore decided combinationally from in_lu_data and registered as the packet flag.
- Config outputs, beacon_update_master and update_cnt update 1 cycle after the tail is sampled. All change in the same cycle.
- Back-to-back packets (tail followed immediately by head) are supported with no idle cycle.
- Reset values:
  - All out_* = 0.
  - direct_mac_addr = 0, direction = 0, token_bucket_para = 0, time_slot_period = 0.
  - beacon_update_master = 0, update_cnt = 0, err_cnt = 0.
  - FSM = IDLE, delay line cleared.
- Reset mid-packet: in-flight words are discarded. Post-reset remaining words are orphans (dropped, err_cnt +1).

## Test plan
- 4-word non-PTP packet (ethertype 0x0800) -> identical words out 3 cycles later, head [87:80]=8'd12, tail valid=1, counters 0.
- 8-word update to local MAC, word 6 = {48'h0a0b0c0d0e0f, 1, 15'b0, 32'h00010002, 32'd1000} -> no out wr. One cycle after tail: config outputs equal these fields, beacon_update_master 0->1, update_cnt=1.
- Same update with dmac ≠ in_local_mac_id -> forwarded intact, config unchanged, beacon_update_master unchanged.
- Update truncated at k=4 (tail) -> nothing forwarded, config unchanged, err_cnt=1.
- Update, then a forward packet, back-to-back with no gap -> the update is consumed, the second packet emerges with 3-cycle latency, no lost words.
- rst asserted at word 3 of a 6-word forward packet -> outputs 0 immediately. After release, words 4-5 are dropped, err_cnt=1.
